// File: rtl/sejf_pkg.sv
// Shared encoder/decoder definitions: quadrature AB codes,
// transmitter phase states and CW/CCW phase tables.
package sejf_pkg;

  localparam logic [1:0] DEC_ST_00 = 2'b00;
  localparam logic [1:0] DEC_ST_10 = 2'b10;
  localparam logic [1:0] DEC_ST_11 = 2'b11;
  localparam logic [1:0] DEC_ST_01 = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PH1  = 3'd1,
    ST_PH2  = 3'd2,
    ST_PH3  = 3'd3,
    ST_PH4  = 3'd4
  } tx_state_e;

  // Index 0 is PH1; A leads B for CW, B leads A for CCW.
  localparam logic [3:0][1:0] AB_CW = {
    DEC_ST_00, DEC_ST_01, DEC_ST_11, DEC_ST_10
  };
  localparam logic [3:0][1:0] AB_CCW = {
    DEC_ST_00, DEC_ST_10, DEC_ST_11, DEC_ST_01
  };

  function automatic logic [1:0] phase_ab(
    input logic [1:0] ph,
    input logic       dir
  );
    return dir ? AB_CW[ph] : AB_CCW[ph];
  endfunction

endpackage

// File: rtl/quad_encoder_tx_dwell_timer.sv
// Phase dwell timer: load on phase entry, o_tc high
// during the last cycle of a DWELL-cycle phase.
module dwell_timer #(
  parameter int DWELL = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  output logic o_tc
);

  localparam int CW = $clog2(DWELL + 1);
  localparam logic [CW-1:0] ONE  = CW'(1);
  localparam logic [CW-1:0] LOAD = CW'(DWELL);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= LOAD;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - ONE;
    end
  end

  assign o_tc = (r_cnt == ONE);

endmodule

// File: rtl/quad_encoder_tx.sv
// Detented rotary encoder emulator: one accepted step
// emits a full AB quadrature cycle and updates pos.
module quad_encoder_tx
  import sejf_pkg::*;
#(
  parameter int DWELL = 4,
  parameter int POS_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step_valid,
  input  logic             step_dir,
  output logic             step_ready,
  output logic             chan_a,
  output logic             chan_b,
  output logic             step_done,
  output logic [POS_W-1:0] pos
);

  localparam logic [POS_W-1:0] P_ONE = POS_W'(1);

  tx_state_e        r_state;
  logic             r_dir;
  logic [1:0]       r_ab;
  logic             r_ready;
  logic             r_done;
  logic [POS_W-1:0] r_pos;

  logic w_accept;
  logic w_mid;
  logic w_load;
  logic w_tc;

  assign w_accept = (r_state == ST_IDLE) && r_ready && step_valid;
  assign w_mid    = r_state inside {ST_PH1, ST_PH2, ST_PH3};
  assign w_load   = w_accept || (w_tc && w_mid);

  dwell_timer #(
    .DWELL (DWELL)
  ) u_dwell (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_load),
    .o_tc   (w_tc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_dir   <= 1'b0;
      r_ab    <= 2'b00;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
      r_pos   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_ab    <= 2'b00;
          r_ready <= 1'b1;
          if (w_accept) begin
            r_state <= ST_PH1;
            r_dir   <= step_dir;
            r_ab    <= phase_ab(2'd0, step_dir);
            r_ready <= 1'b0;
          end
        end
        ST_PH1: begin
          if (w_tc) begin
            r_state <= ST_PH2;
            r_ab    <= phase_ab(2'd1, r_dir);
          end
        end
        ST_PH2: begin
          if (w_tc) begin
            r_state <= ST_PH3;
            r_ab    <= phase_ab(2'd2, r_dir);
          end
        end
        ST_PH3: begin
          if (w_tc) begin
            r_state <= ST_PH4;
            r_ab    <= phase_ab(2'd3, r_dir);
          end
        end
        ST_PH4: begin
          if (w_tc) begin
            r_state <= ST_IDLE;
            r_ab    <= 2'b00;
            r_ready <= 1'b1;
            r_done  <= 1'b1;
            r_pos   <= r_dir ? r_pos + P_ONE
                             : r_pos - P_ONE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_ab    <= 2'b00;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign step_ready = r_ready;
  assign chan_a     = r_ab[1];
  assign chan_b     = r_ab[0];
  assign step_done  = r_done;
  assign pos        = r_pos;

endmodule

// File: tb/tb_quad_encoder_tx.sv
// Self-checking bench for quad_encoder_tx (DWELL=4 and
// DWELL=1 instances) against a behavioural step model.
module tb_quad_encoder_tx;

  localparam int D4 = 4;
  localparam logic [1:0] CW_T  [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
  localparam logic [1:0] CCW_T [4] = '{2'b01, 2'b11, 2'b10, 2'b00};

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic       valid = 1'b0, dir = 1'b0;
  logic       ready, a, b, done;
  logic [7:0] pos;

  logic       valid1 = 1'b0, dir1 = 1'b0;
  logic       ready1, a1, b1, done1;
  logic [7:0] pos1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  quad_encoder_tx #(.DWELL(4), .POS_W(8)) u_dut (
    .clk(clk), .rst(rst),
    .step_valid(valid), .step_dir(dir),
    .step_ready(ready), .chan_a(a), .chan_b(b),
    .step_done(done), .pos(pos)
  );

  quad_encoder_tx #(.DWELL(1), .POS_W(8)) u_dut1 (
    .clk(clk), .rst(rst),
    .step_valid(valid1), .step_dir(dir1),
    .step_ready(ready1), .chan_a(a1), .chan_b(b1),
    .step_done(done1), .pos(pos1)
  );

  // Step-level reference model: m_k counts cycles since acceptance
  int         m_k = -1;
  bit         m_dir;
  logic [7:0] m_pos = 8'h00;
  logic [1:0] e_ab;
  logic       e_ready, e_done;

  task automatic m_reset();
    m_k = -1;
    m_pos = 8'h00;
  endtask

  task automatic model_edge(input logic v, input logic d);
    if (m_k < 0) begin
      if (v) begin
        m_k = 0;
        m_dir = d;
      end
    end else begin
      m_k++;
    end
    e_done = (m_k == 4 * D4);
    if (e_done) m_pos = m_dir ? m_pos + 8'd1 : m_pos - 8'd1;
    if (m_k >= 0 && m_k < 4 * D4) begin
      e_ab = m_dir ? CW_T[m_k / D4] : CCW_T[m_k / D4];
      e_ready = 1'b0;
    end else begin
      e_ab = 2'b00;
      e_ready = 1'b1;
    end
    if (e_done) m_k = -1;
  endtask

  // Quadrature decoder model: counts edges, 4 per detent
  int         dec_cnt = 0;
  int         dec_bad = 0;
  logic [1:0] dec_prev = 2'b00;

  function automatic int gidx(input logic [1:0] ab);
    case (ab)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  task automatic dec_sample(input logic [1:0] ab);
    int dl;
    dl = (gidx(ab) - gidx(dec_prev)) & 3;
    if (dl == 1) dec_cnt++;
    else if (dl == 3) dec_cnt--;
    else if (dl == 2) dec_bad++;
    dec_prev = ab;
  endtask

  task automatic apply_reset();
    valid = 1'b0;
    valid1 = 1'b0;
    rst = 1'b0;
    m_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    valid = 1'b1;
    dir = 1'b1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({a, b, ready, done, pos} !== {2'b00, 1'b1, 1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_dut4 got=%h want=%h",
               {a, b, ready, done, pos}, {2'b00, 1'b1, 1'b0, 8'h00});
    end
    n_tests++;
    if ({a1, b1, ready1, done1, pos1} !== {2'b00, 1'b1, 1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_dut1 got=%h want=%h",
               {a1, b1, ready1, done1, pos1}, {2'b00, 1'b1, 1'b0, 8'h00});
    end
    valid = 1'b0;
  endtask

  task automatic test_reset_accept();
    rst = 1'b0;
    valid = 1'b1;
    dir = 1'b1;
    m_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    for (int j = 0; j < 4 * D4 + 3; j++) begin
      @(posedge clk);
      model_edge(valid, dir);
      #1;
      n_tests++;
      if ({a, b, ready, done, pos} !== {e_ab, e_ready, e_done, m_pos}) begin
        n_fail++;
        $display("FAIL first_edge_accept j=%0d got=%h want=%h", j,
                 {a, b, ready, done, pos}, {e_ab, e_ready, e_done, m_pos});
      end
      if (j == 0) valid = 1'b0;
    end
    n_tests++;
    if (pos !== 8'h01) begin
      n_fail++;
      $display("FAIL first_edge_pos got=%h want=01", pos);
    end
  endtask

  task automatic test_step(input logic d);
    int chg[$];
    int done_cyc;
    int ndone;
    logic [1:0] prev;
    apply_reset();
    ndone = 0;
    done_cyc = -1;
    prev = 2'b00;
    @(negedge clk);
    valid = 1'b1;
    dir = d;
    for (int j = 0; j < 4 * D4 + 3; j++) begin
      @(posedge clk);
      model_edge(valid, dir);
      #1;
      n_tests++;
      if ({a, b, ready, done, pos} !== {e_ab, e_ready, e_done, m_pos}) begin
        n_fail++;
        $display("FAIL step_dir%0d j=%0d got=%h want=%h", d, j,
                 {a, b, ready, done, pos}, {e_ab, e_ready, e_done, m_pos});
      end
      if ({a, b} != prev) chg.push_back(j);
      prev = {a, b};
      if (done) begin
        ndone++;
        done_cyc = j;
      end
      if (j == 0) valid = 1'b0;
    end
    n_tests++;
    if (!(chg.size() == 4 && chg[0] == 0 && chg[1] == 4 &&
          chg[2] == 8 && chg[3] == 12)) begin
      n_fail++;
      $display("FAIL step_dir%0d_ab_times got=%0d changes want=4 at 0,4,8,12",
               d, chg.size());
    end
    n_tests++;
    if (ndone != 1 || done_cyc != 16) begin
      n_fail++;
      $display("FAIL step_dir%0d_done got=%0d@%0d want=1@16", d, ndone, done_cyc);
    end
    n_tests++;
    if (pos !== (d ? 8'h01 : 8'hFF)) begin
      n_fail++;
      $display("FAIL step_dir%0d_pos got=%h want=%h", d, pos,
               d ? 8'h01 : 8'hFF);
    end
  endtask

  task automatic test_back_to_back();
    int dcyc[$];
    logic [7:0] dpos[$];
    apply_reset();
    for (int j = 0; j < 3 * 17 + 2; j++) begin
      @(negedge clk);
      valid = 1'b1;
      dir = (j % 2 == 0);
      @(posedge clk);
      model_edge(valid, dir);
      #1;
      n_tests++;
      if ({a, b, ready, done, pos} !== {e_ab, e_ready, e_done, m_pos}) begin
        n_fail++;
        $display("FAIL back_to_back j=%0d got=%h want=%h", j,
                 {a, b, ready, done, pos}, {e_ab, e_ready, e_done, m_pos});
      end
      if (done) begin
        dcyc.push_back(j);
        dpos.push_back(pos);
      end
    end
    valid = 1'b0;
    n_tests++;
    if (!(dcyc.size() == 3 && dcyc[0] == 16 && dcyc[1] == 33 &&
          dcyc[2] == 50)) begin
      n_fail++;
      $display("FAIL back_to_back_period got=%0d dones want=3 at 16,33,50",
               dcyc.size());
    end
    n_tests++;
    if (!(dpos.size() == 3 && dpos[0] == 8'h01 && dpos[1] == 8'h00 &&
          dpos[2] == 8'h01)) begin
      n_fail++;
      $display("FAIL back_to_back_pos got=%0d values want=1,0,1", dpos.size());
    end
  endtask

  task automatic test_wrap();
    int ndone;
    logic [7:0] p127;
    apply_reset();
    ndone = 0;
    p127 = 8'h00;
    @(negedge clk);
    valid = 1'b1;
    dir = 1'b1;
    for (int j = 0; j < 128 * 17; j++) begin
      @(posedge clk);
      model_edge(valid, dir);
      #1;
      n_tests++;
      if ({a, b, ready, done, pos} !== {e_ab, e_ready, e_done, m_pos}) begin
        n_fail++;
        $display("FAIL wrap j=%0d got=%h want=%h", j,
                 {a, b, ready, done, pos}, {e_ab, e_ready, e_done, m_pos});
      end
      if (done) begin
        ndone++;
        if (ndone == 127) p127 = pos;
      end
    end
    valid = 1'b0;
    n_tests++;
    if (p127 !== 8'h7F || pos !== 8'h80 || ndone != 128) begin
      n_fail++;
      $display("FAIL wrap_final got=%h/%h n=%0d want=7f/80 n=128",
               p127, pos, ndone);
    end
  endtask

  task automatic test_reset_mid_step();
    int seen;
    apply_reset();
    seen = 0;
    @(negedge clk);
    valid = 1'b1;
    dir = 1'b1;
    for (int j = 0; j <= 6; j++) begin
      @(posedge clk);
      model_edge(valid, dir);
      #1;
      n_tests++;
      if ({a, b, ready, done, pos} !== {e_ab, e_ready, e_done, m_pos}) begin
        n_fail++;
        $display("FAIL mid_step_pre j=%0d got=%h want=%h", j,
                 {a, b, ready, done, pos}, {e_ab, e_ready, e_done, m_pos});
      end
      if (j == 0) valid = 1'b0;
    end
    rst = 1'b0;
    #1;
    n_tests++;
    if ({a, b, ready, done, pos} !== {2'b00, 1'b1, 1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL mid_step_async got=%h want=%h",
               {a, b, ready, done, pos}, {2'b00, 1'b1, 1'b0, 8'h00});
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    m_reset();
    for (int j = 0; j < 20; j++) begin
      @(posedge clk);
      #1;
      if (done) seen++;
    end
    n_tests++;
    if (seen != 0 || pos !== 8'h00 || {a, b} !== 2'b00) begin
      n_fail++;
      $display("FAIL mid_step_after got=done%0d pos=%h ab=%b want=done0 pos=00 ab=00",
               seen, pos, {a, b});
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int j = 0; j < 600; j++) begin
      @(negedge clk);
      valid = ($urandom_range(0, 3) == 0);
      dir = 1'($urandom_range(0, 1));
      @(posedge clk);
      model_edge(valid, dir);
      #1;
      n_tests++;
      if ({a, b, ready, done, pos} !== {e_ab, e_ready, e_done, m_pos}) begin
        n_fail++;
        $display("FAIL random j=%0d got=%h want=%h", j,
                 {a, b, ready, done, pos}, {e_ab, e_ready, e_done, m_pos});
      end
    end
    valid = 1'b0;
  endtask

  task automatic test_dwell1();
    logic [1:0] exp_ab;
    apply_reset();
    dec_cnt = 0;
    dec_bad = 0;
    dec_prev = 2'b00;
    @(negedge clk);
    valid1 = 1'b1;
    dir1 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      dec_sample({a1, b1});
      exp_ab = (k < 4) ? CW_T[k] : 2'b00;
      n_tests++;
      if ({a1, b1, ready1} !== {exp_ab, k == 4}) begin
        n_fail++;
        $display("FAIL dwell1_step k=%0d got=%b want=%b", k,
                 {a1, b1, ready1}, {exp_ab, k == 4});
      end
      if (k == 0) valid1 = 1'b0;
    end
    n_tests++;
    if (pos1 !== 8'h01) begin
      n_fail++;
      $display("FAIL dwell1_pos got=%h want=01", pos1);
    end
    for (int j = 0; j < 300; j++) begin
      @(negedge clk);
      valid1 = 1'($urandom_range(0, 1));
      dir1 = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      dec_sample({a1, b1});
    end
    valid1 = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
      dec_sample({a1, b1});
    end
    n_tests++;
    if (pos1 !== 8'(dec_cnt / 4) || dec_bad != 0) begin
      n_fail++;
      $display("FAIL dwell1_decoder got=%h want=%h bad=%0d",
               pos1, 8'(dec_cnt / 4), dec_bad);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_reset_accept();
    test_step(1'b1);
    test_step(1'b0);
    test_back_to_back();
    test_wrap();
    test_reset_mid_step();
    test_random();
    test_dwell1();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
